// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and result width shared by the ALU arbiter and its ALU
package alu_pkg;
  localparam int ALU_RES_W = 16;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_ONES = 2'b11;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational 8-bit ALU (add, sub, mul, all-ones) with carry/borrow flag
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [1:0]           sel,
  input  logic [7:0]           a,
  input  logic [7:0]           b,
  input  logic                 c,
  output logic [ALU_RES_W-1:0] out,
  output logic                 flag
);
  logic [8:0] sum;
  logic [8:0] diff;
  assign sum  = {1'b0, a} + {1'b0, b} + {8'b0, c};
  assign diff = {1'b0, a} - {1'b0, b} - {8'b0, c};
  assign out  = sel == OP_ADD ? {8'b0, sum[7:0]} :
                sel == OP_SUB ? {8'b0, diff[7:0]} :
                sel == OP_MUL ? {8'b0, a} * {8'b0, b} : '1;
  assign flag = sel == OP_ADD ? sum[8] : sel == OP_SUB ? diff[8] : 1'b0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end for the shared ALU; ALU_ARB_STATS_EN adds saturating accept counters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [1:0]           req0_sel,
  input  logic [1:0]           req1_sel,
  input  logic [7:0]           req0_a,
  input  logic [7:0]           req0_b,
  input  logic [7:0]           req1_a,
  input  logic [7:0]           req1_b,
  input  logic                 req0_c,
  input  logic                 req1_c,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [ALU_RES_W-1:0] rsp_out,
  output logic                 rsp_flag
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]          stat_cnt0,
  output logic [15:0]          stat_cnt1
`endif
);
  state_t state;
  logic [$clog2(NREQ)-1:0] last_grant;
  logic [$clog2(NREQ)-1:0] grant;
  logic [$clog2(NREQ)-1:0] op_id;
  logic [1:0] op_sel;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic op_c;
  logic [ALU_RES_W-1:0] alu_out;
  logic alu_flag;
  // On a tie the requester not granted last wins; otherwise whoever is valid
  assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = (state == S_IDLE) && req0_valid && !grant;
  assign req1_ready = (state == S_IDLE) && req1_valid && grant;
  alu_arbiter_alu u_alu (
    .sel  (op_sel),
    .a    (op_a),
    .b    (op_b),
    .c    (op_c),
    .out  (alu_out),
    .flag (alu_flag)
  );
  // Accept the winner's operands, run one ALU cycle, hold the result until the consumer takes it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      op_id      <= '0;
      op_sel     <= OP_ADD;
      op_a       <= '0;
      op_b       <= '0;
      op_c       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_out    <= '0;
      rsp_flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (req0_ready || req1_ready) begin
            op_sel     <= grant ? req1_sel : req0_sel;
            op_a       <= grant ? req1_a : req0_a;
            op_b       <= grant ? req1_b : req0_b;
            op_c       <= grant ? req1_c : req0_c;
            op_id      <= grant;
            last_grant <= grant;
            state      <= S_EXEC;
          end
        S_EXEC: begin
          rsp_out   <= alu_out;
          rsp_flag  <= alu_flag;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
`ifdef ALU_ARB_STATS_EN
  // Count accepted operations per requester, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else begin
      if (req0_ready && stat_cnt0 != 16'hFFFF) stat_cnt0 <= stat_cnt0 + 16'd1;
      if (req1_ready && stat_cnt1 != 16'hFFFF) stat_cnt1 <= stat_cnt1 + 16'd1;
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter; define ALU_ARB_STATS_EN to also exercise the counters
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [1:0] req0_sel = 2'b00, req1_sel = 2'b00;
  logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
  logic req0_c = 1'b0, req1_c = 1'b0;
  logic rsp_valid, rsp_id, rsp_flag;
  logic rsp_ready = 1'b0;
  logic [15:0] rsp_out;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1;
`endif
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic        id;
    logic [15:0] out;
    logic        flag;
  } rsp_t;
  rsp_t sb[$];
  logic ids[$];
  time tms[$];

  alu_arbiter #(.NREQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_c(req0_c), .req1_c(req1_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flag(rsp_flag)
`ifdef ALU_ARB_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic rsp_t expect_rsp(logic id, logic [1:0] sel, logic [7:0] a, logic [7:0] b, logic c);
    rsp_t e;
    int r;
    e.id = id;
    e.flag = 1'b0;
    e.out = 16'hFFFF;
    if (sel == 2'b00) begin
      r = int'(a) + int'(b) + int'(c);
      e.out = 16'(r % 256);
      e.flag = (r > 255);
    end else if (sel == 2'b01) begin
      r = int'(a) - int'(b) - int'(c);
      e.out = 16'((r + 256) % 256);
      e.flag = (r < 0);
    end else if (sel == 2'b10) begin
      e.out = 16'(int'(a) * int'(b));
    end
    return e;
  endfunction

  // Push expectations on accept, compare on response handshake
  always @(negedge clk) begin
    if (rst_n && req0_valid && req0_ready) sb.push_back(expect_rsp(1'b0, req0_sel, req0_a, req0_b, req0_c));
    if (rst_n && req1_valid && req1_ready) sb.push_back(expect_rsp(1'b1, req1_sel, req1_a, req1_b, req1_c));
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got id=%0d out=%h flag=%b, none expected", rsp_id, rsp_out, rsp_flag);
      end else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_out, rsp_flag} !== {e.id, e.out, e.flag}) begin
          errors++;
          $display("FAIL sb_rsp: got id=%0d out=%h flag=%b want id=%0d out=%h flag=%b",
                   rsp_id, rsp_out, rsp_flag, e.id, e.out, e.flag);
        end
      end
      ids.push_back(rsp_id);
      tms.push_back($time);
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin @(negedge clk); #1; end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL %s_drain: got %0d pending want 0", name, sb.size()); end
  endtask

  task automatic test_reset;
    #7;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", req1_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %b want 0", rsp_id); end
    checks++; if (rsp_out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", rsp_out); end
    checks++; if (rsp_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", rsp_flag); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    @(posedge clk); #1;
    rsp_ready = 1'b1; req0_sel = 2'b00; req0_a = 8'd200; req0_b = 8'd100; req0_c = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL add_ready: got %b%b want 10", req0_ready, req1_ready); end
    @(posedge clk); #1; req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_exec_valid: got %b want 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if ({rsp_id, rsp_out, rsp_flag} !== {1'b0, 16'h002C, 1'b1}) begin
      errors++; $display("FAIL add_result: got id=%0d out=%h flag=%b want id=0 out=002c flag=1", rsp_id, rsp_out, rsp_flag);
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_after_hs: got %b want 0", rsp_valid); end
  endtask

  task automatic test_mul;
    @(posedge clk); #1;
    req1_sel = 2'b10; req1_a = 8'd15; req1_b = 8'd17; req1_c = 1'b1; req1_valid = 1'b1;
    @(posedge clk); #1; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if ({rsp_valid, rsp_id, rsp_out, rsp_flag} !== {1'b1, 1'b1, 16'h00FF, 1'b0}) begin
      errors++; $display("FAIL mul_result: got v=%b id=%0d out=%h flag=%b want v=1 id=1 out=00ff flag=0", rsp_valid, rsp_id, rsp_out, rsp_flag);
    end
    drain("mul");
  endtask

  task automatic test_round_robin;
    logic exp_ids [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    ids.delete(); tms.delete();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req0_sel = 2'b01; req0_a = 8'd5; req0_b = 8'd9; req0_c = 1'b1;
    req1_sel = 2'b11; req1_a = 8'd3; req1_b = 8'd4; req1_c = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 40 && ids.size() < 4; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (ids.size() != 4) begin errors++; $display("FAIL rr_count: got %0d want 4", ids.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (ids[k] !== exp_ids[k]) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", k, ids[k], exp_ids[k]); end
      end
      for (int k = 0; k < 3; k++) begin
        checks++; if (tms[k+1] - tms[k] != 30) begin errors++; $display("FAIL rr_interval%0d: got %0t want 30", k, tms[k+1] - tms[k]); end
      end
    end
    drain("rr");
  endtask

  task automatic test_backpressure;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_sel = 2'b10; req0_a = 8'd12; req0_b = 8'd11; req0_valid = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_sel = 2'b00; req1_a = 8'd1; req1_b = 8'd2; req1_c = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_out, rsp_flag, req0_ready, req1_ready} !== {1'b1, 1'b0, 16'h0084, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d out=%h flag=%b rdy=%b%b want v=1 id=0 out=0084 flag=0 rdy=00",
                 i, rsp_valid, rsp_id, rsp_out, rsp_flag, req0_ready, req1_ready);
      end
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got %b want 1", req1_ready); end
    @(posedge clk); #1; req1_valid = 1'b0;
    drain("bp");
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    checks++; if ({rsp_valid, rsp_out} !== {1'b0, 16'h0000}) begin
      errors++; $display("FAIL mid_reset: got v=%b out=%h want v=0 out=0000", rsp_valid, rsp_out);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: got %b want 0", i, rsp_valid); end
    end
    @(posedge clk); #1;
    req0_sel = 2'b00; req0_a = 8'd255; req0_b = 8'd0; req0_c = 1'b1;
    req1_sel = 2'b01; req1_a = 8'd0; req1_b = 8'd1; req1_c = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL mid_tie: got %b%b want 10", req0_ready, req1_ready); end
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    drain("mid");
  endtask

  task automatic test_random;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_sel = 2'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom); req0_c = 1'($urandom);
      req1_sel = 2'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom); req1_c = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    drain("rand");
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats;
    @(posedge clk); #1; rst_n = 1'b0; rsp_ready = 1'b1;
    #3;
    checks++; if ({stat_cnt0, stat_cnt1} !== 32'h0) begin errors++; $display("FAIL stat_reset: got %h %h want 0 0", stat_cnt0, stat_cnt1); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k < 5) req0_valid = 1'b1; else req1_valid = 1'b1;
      @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) @(posedge clk);
    end
    @(negedge clk);
    checks++; if (stat_cnt0 !== 16'd5) begin errors++; $display("FAIL stat_cnt0: got %0d want 5", stat_cnt0); end
    checks++; if (stat_cnt1 !== 16'd3) begin errors++; $display("FAIL stat_cnt1: got %0d want 3", stat_cnt1); end
    force dut.stat_cnt0 = 16'hFFFF;
    @(posedge clk); #1;
    release dut.stat_cnt0;
    req0_valid = 1'b1;
    @(posedge clk); #1; req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (stat_cnt0 !== 16'hFFFF) begin errors++; $display("FAIL stat_sat: got %h want ffff", stat_cnt0); end
    drain("stat");
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_mul;
    test_round_robin;
    test_backpressure;
    test_reset_mid;
    test_random;
`ifdef ALU_ARB_STATS_EN
    test_stats;
`endif
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
